ysyx_25040129_ifu: RTL
======================

Name: ysyx_25040129_ifu

Overview:
Instruction fetch unit: the producer end of the IFU→IDU valid/ready handshake. It fetches 32-bit instructions from a single-outstanding request/response memory port, holds each one until the decode stage accepts it, and then fetches PC+4. Redirects from the back end (branch, jump, ecall, mret, fence.i) flush the wrong-path instruction, including any fetch still in flight.

Parameters:
RESET_PC, 32'h3000_0000, first fetch address after reset
ADDR_W, 32, PC / memory address width

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high reset
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  fetch address, word-aligned
mem_resp_valid  in  1  response data valid; the memory never back-pressures it
mem_resp_data  in  32  fetched instruction word
mem_resp_err  in  1  access fault on this response
inst  out  32  instruction presented to decode
pc  out  ADDR_W  PC of inst
fetch_err_out_ifu  out  1  inst came from a faulted fetch
is_req_valid_to_idu  out  1  inst/pc valid
is_req_ready_from_idu  in  1  decode accepts; low while decode is stalled on a hazard
redirect_valid  in  1  one-cycle redirect pulse
redirect_pc  in  ADDR_W  redirect target

Behaviour:
- One clock (clock). Reset is synchronous and active-high. Every register updates on the rising edge of clock.
- Reset values:
  - state=REQ; fetch_pc=RESET_PC; drop=0.
  - inst=0, pc=0, fetch_err_out_ifu=0.
  - mem_req_valid goes high in the first cycle after reset is released.
- States:
  - REQ: mem_req_valid=1, mem_req_addr=fetch_pc. Go to WAIT on mem_req_valid&&mem_req_ready.
  - WAIT: wait for mem_resp_valid.
    - If drop=1: discard the response, clear drop, go to REQ (fetch_pc already holds the redirect target).
    - If drop=0: latch inst=mem_resp_data, pc=fetch_pc, fetch_err_out_ifu=mem_resp_err; go to HOLD.
  - HOLD: is_req_valid_to_idu=1 and !redirect_valid.
    - On handshake: fetch_pc<=fetch_pc+4 (wraps modulo 2^ADDR_W); go to REQ.
    - While ready is low, inst, pc and valid stay stable for any number of cycles.
- Latency: request issue → valid at decode is ≥2 cycles (REQ→WAIT→HOLD with zero-wait memory). With zero-wait memory and decode always ready, one instruction is delivered every 3 cycles.
- Redirect handling (target = {redirect_pc[ADDR_W-1:2],2'b00}; misaligned low bits are cleared):
  - In REQ, not yet accepted: mem_req_addr stays unchanged (request stability rule). Set fetch_pc to the target and drop<=1, but mem_req_addr continues to show the address captured at entry to REQ (use a separate req_addr register). Alternatively, a request may be retargeted only when mem_req_ready=0 is not permitted; the captured-address approach is the required one.
  - In REQ, accepted in the same cycle: set drop<=1 and fetch_pc<=target; go to WAIT.
  - In WAIT: drop<=1 and fetch_pc<=target. If the response arrives in the same cycle, discard it and go to REQ.
  - In HOLD: the held instruction is discarded. Valid is gated low that cycle, so no handshake occurs. fetch_pc<=target; go to REQ.
- Redirect has priority over every other event in the same cycle.
- When the REQ-stage drop completes (response discarded), the next request uses fetch_pc, i.e. the latest redirect target. If multiple redirects arrive before that, the last one wins.
- Faulted fetch: the instruction is delivered with fetch_err_out_ifu=1. The back end handles the trap and redirects.
- Reset asserted mid-operation (in any state) returns the unit to the reset values. Any outstanding response arriving afterwards is ignored: WAIT is not entered until a new request is accepted.

Optional Feature:
YSYX_25040129_IFU_PERF_EN
- Defined: adds 32-bit saturating counters, readable on outputs perf_fetch_cnt, perf_stall_cnt and perf_flush_cnt:
  - perf_fetch_cnt: incremented on each decode handshake.
  - perf_stall_cnt: incremented each HOLD cycle with valid=1 and ready=0.
  - perf_flush_cnt: incremented on each redirect pulse.
  - All three reset to 0.
- Undefined: these ports and counters do not exist. Functional behaviour is identical in both cases.

Decomposition:
- Shared defines header: IFU state encodings (REQ=2'd0, WAIT=2'd1, HOLD=2'd2), RESET_PC default, and the INST_NOP constant 32'h0000_0013 for bench use.
- No sub-module is needed. The optional counters may optionally be placed in ysyx_25040129_ifu_perf.

Test Plan:
1. Reset, zero-wait memory returning 32'h00000013, decode always ready → first request addr 0x30000000; pc sequence 0x30000000, 0x30000004, 0x30000008, each delivered 3 cycles apart.
2. Decode ready held low 5 cycles in HOLD → inst/pc/valid stable for all 5 cycles; no new mem_req_valid; fetch_pc advances only after the handshake.
3. Redirect to 0x30000100 while in WAIT, response arrives 2 cycles later → response discarded, next request addr 0x30000100, first delivered pc=0x30000100.
4. Redirect to 0x30000203 in the same cycle as a HOLD handshake attempt → no handshake occurs; next request addr 0x30000200.
5. mem_resp_err=1 on fetch at 0x30000008 → delivered with fetch_err_out_ifu=1 and pc=0x30000008.
6. fetch_pc=0xFFFFFFFC handshake → next request addr 0x00000000; reset asserted during WAIT → request restarts at RESET_PC, and the stale response is ignored.

Source files
------------

// File: rtl/ysyx_25040129_ifu_pkg.sv
// Shared definitions for the ysyx_25040129 instruction fetch unit:
// FSM state encodings, the default reset PC, the canonical NOP word and a
// saturating-increment helper used by the optional performance counters.
package ysyx_25040129_ifu_pkg;

  // Fetch FSM states. The encodings are fixed so that waveforms and any
  // external debug tooling agree on their meaning.
  typedef enum logic [1:0] {
    IFU_REQ  = 2'd0,  // request presented to memory
    IFU_WAIT = 2'd1,  // request accepted, waiting for the response
    IFU_HOLD = 2'd2   // instruction held for decode
  } ifu_state_e;

  // First fetch address after reset.
  localparam logic [31:0] IFU_RESET_PC = 32'h3000_0000;

  // addi x0, x0, 0 -- handy filler word for memories in simulation.
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/ysyx_25040129_ifu_perf.sv
// Optional performance counters for the ysyx_25040129 instruction fetch unit.
// Only present when YSYX_25040129_IFU_PERF_EN is defined; the counters are
// 32-bit and saturate at all-ones.
`ifdef YSYX_25040129_IFU_PERF_EN
module ysyx_25040129_ifu_perf
  import ysyx_25040129_ifu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_fire_i,  // decode handshake this cycle
  input  logic        stall_i,       // instruction offered but decode not ready
  input  logic        flush_i,       // redirect pulse this cycle
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Count events; each counter freezes once it reaches its maximum.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (fetch_fire_i) fetch_cnt_q <= sat_inc(fetch_cnt_q);
      if (stall_i)      stall_cnt_q <= sat_inc(stall_cnt_q);
      if (flush_i)      flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
`endif

// File: rtl/ysyx_25040129_ifu.sv
// ysyx_25040129 instruction fetch unit.
//
// Producer side of the IFU->IDU valid/ready handshake. Fetches one 32-bit
// word at a time over a single-outstanding request/response memory port,
// holds it until decode accepts it, then fetches PC+4. A redirect pulse from
// the back end discards the wrong-path instruction, including a fetch that is
// still in flight (tracked with the drop flag).
//
// Build option: define YSYX_25040129_IFU_PERF_EN to add the saturating
// performance counter outputs perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt.
module ysyx_25040129_ifu
  import ysyx_25040129_ifu_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
  input  logic              clock,
  input  logic              reset,

  // Memory request/response port (one request outstanding at a time)
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data,
  input  logic              mem_resp_err,

  // Decode interface
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_err_out_ifu,
  output logic              is_req_valid_to_idu,
  input  logic              is_req_ready_from_idu,

  // Back-end redirect
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef YSYX_25040129_IFU_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  ifu_state_e        state_q;
  logic [ADDR_W-1:0] fetch_pc_q;  // address of the next instruction to deliver
  logic [ADDR_W-1:0] req_addr_q;  // address frozen on entry to REQ
  logic              drop_q;      // the in-flight (or next) response is wrong-path
  logic [31:0]       inst_q;
  logic [ADDR_W-1:0] pc_q;
  logic              err_q;

  // ---------------------------------------------------------------------------
  // Derived signals
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] redirect_tgt;
  logic [ADDR_W-1:0] fetch_pc_inc;
  logic              req_fire;
  logic              idu_valid;
  logic              idu_fire;

  // Redirect targets are forced word-aligned; the low two bits are cleared.
  assign redirect_tgt = redirect_pc & ~ADDR_W'(3);
  assign fetch_pc_inc = fetch_pc_q + ADDR_W'(4);

  assign mem_req_valid = (state_q == IFU_REQ);
  assign mem_req_addr  = req_addr_q;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // A redirect in the same cycle kills the held instruction, so valid is
  // masked to make a handshake impossible in that cycle.
  assign idu_valid = (state_q == IFU_HOLD) && !redirect_valid;
  assign idu_fire  = idu_valid && is_req_ready_from_idu;

  assign is_req_valid_to_idu = idu_valid;
  assign inst                = inst_q;
  assign pc                  = pc_q;
  assign fetch_err_out_ifu   = err_q;

  // ---------------------------------------------------------------------------
  // Fetch FSM: request -> wait for response -> hold for decode.
  // Redirect takes priority over every other event in a cycle. req_addr_q is
  // only loaded on the transition into REQ, so a redirect arriving while a
  // request is pending never changes the address the memory is looking at;
  // the stale request is completed and its response dropped instead.
  // ---------------------------------------------------------------------------
  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IFU_REQ;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      drop_q     <= 1'b0;
      inst_q     <= '0;
      pc_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IFU_REQ: begin
          if (redirect_valid) begin
            fetch_pc_q <= redirect_tgt;
            drop_q     <= 1'b1;
          end
          if (req_fire) begin
            state_q <= IFU_WAIT;
          end
        end

        IFU_WAIT: begin
          if (redirect_valid) begin
            fetch_pc_q <= redirect_tgt;
            if (mem_resp_valid) begin
              // The response is wrong-path and consumed right now.
              drop_q     <= 1'b0;
              req_addr_q <= redirect_tgt;
              state_q    <= IFU_REQ;
            end else begin
              drop_q <= 1'b1;
            end
          end else if (mem_resp_valid) begin
            if (drop_q) begin
              // fetch_pc_q already holds the latest redirect target.
              drop_q     <= 1'b0;
              req_addr_q <= fetch_pc_q;
              state_q    <= IFU_REQ;
            end else begin
              inst_q  <= mem_resp_data;
              pc_q    <= fetch_pc_q;
              err_q   <= mem_resp_err;
              state_q <= IFU_HOLD;
            end
          end
        end

        IFU_HOLD: begin
          if (redirect_valid) begin
            fetch_pc_q <= redirect_tgt;
            req_addr_q <= redirect_tgt;
            state_q    <= IFU_REQ;
          end else if (idu_fire) begin
            fetch_pc_q <= fetch_pc_inc;
            req_addr_q <= fetch_pc_inc;
            state_q    <= IFU_REQ;
          end
        end

        default: begin
          state_q <= IFU_REQ;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef YSYX_25040129_IFU_PERF_EN
  ysyx_25040129_ifu_perf u_perf (
    .clock       (clock),
    .reset       (reset),
    .fetch_fire_i(idu_fire),
    .stall_i     (idu_valid && !is_req_ready_from_idu),
    .flush_i     (redirect_valid),
    .fetch_cnt_o (perf_fetch_cnt),
    .stall_cnt_o (perf_stall_cnt),
    .flush_cnt_o (perf_flush_cnt)
  );
`endif

endmodule
